// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux into one registered output stage.
// Define MUX_RR_ARBITER_GRANT_CNT_EN to add saturating per-requester accept counters.
module mux_rr_arbiter #(
   parameter int width_size = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   input  logic [width_size:0]   req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [width_size:0]   req1_data,
   output logic                  req1_ready,
   output logic                  out_valid,
   output logic [width_size:0]   out_data,
   input  logic                  out_ready,
   output logic                  mux_sel,
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
   input  logic                  cnt_clr,
   output logic [7:0]            grant_cnt0,
   output logic [7:0]            grant_cnt1,
`endif
   output logic                  out_src
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state_q, state_d;
   logic [width_size:0]   out_data_q, out_data_d;
   logic                  out_src_q, out_src_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant0, grant1;
   logic                  space;
   logic                  accept;
   logic [width_size:0]   mux_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   // With no valid requester the select parks on the last winner.
   always_comb begin
      mux_sel = last_grant_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      if (req0_valid && req1_valid) begin
         mux_sel = !last_grant_q;
         grant0  = last_grant_q;
         grant1  = !last_grant_q;
      end else if (req0_valid) begin
         mux_sel = 1'b0;
         grant0  = 1'b1;
      end else if (req1_valid) begin
         mux_sel = 1'b1;
         grant1  = 1'b1;
      end
   end

   assign space      = (state_q == EMPTY) || out_ready;
   assign req0_ready = grant0 && space && rst_n;
   assign req1_ready = grant1 && space && rst_n;
   assign accept     = req0_ready || req1_ready;
   assign mux_out    = mux_sel ? req1_data : req0_data;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (out_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         out_data_d   = mux_out;
         out_src_d    = mux_sel;
         last_grant_d = mux_sel;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
   logic [7:0] cnt0_q, cnt0_d;
   logic [7:0] cnt1_q, cnt1_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   // Clear wins over increment; counts stick at 255.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (cnt_clr) begin
         cnt0_d = 8'd0;
         cnt1_d = 8'd0;
      end else begin
         if (req0_ready && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
         if (req1_ready && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter with a scoreboard of expected output words.
// Counter checks are included when MUX_RR_ARBITER_GRANT_CNT_EN is defined.
module tb_mux_rr_arbiter;

   typedef struct packed {
      logic [2:0] data;
      logic       src;
   } expWord_t;

   logic       clk;
   logic       rst_n;
   logic       req0Valid, req1Valid;
   logic [2:0] req0Data, req1Data;
   logic       req0Ready, req1Ready;
   logic       outValid;
   logic [2:0] outData;
   logic       outReady;
   logic       muxSel;
   logic       outSrc;
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
   logic       cntClr;
   logic [7:0] grantCnt0, grantCnt1;
`endif

   expWord_t   scoreboard[$];
   int         testCount = 0;
   int         failCount = 0;

   mux_rr_arbiter #(.width_size(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0Valid),
      .req0_data  (req0Data),
      .req0_ready (req0Ready),
      .req1_valid (req1Valid),
      .req1_data  (req1Data),
      .req1_ready (req1Ready),
      .out_valid  (outValid),
      .out_data   (outData),
      .out_ready  (outReady),
      .mux_sel    (muxSel),
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
      .cnt_clr    (cntClr),
      .grant_cnt0 (grantCnt0),
      .grant_cnt1 (grantCnt1),
`endif
      .out_src    (outSrc)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive all requester/consumer inputs and let combinational paths settle
   task automatic applyStimulus(input logic v0, input logic [2:0] d0,
                                input logic v1, input logic [2:0] d1,
                                input logic ordy);
      req0Valid = v0;
      req0Data  = d0;
      req1Valid = v1;
      req1Data  = d1;
      outReady  = ordy;
      #2;
   endtask

   // One comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record the word expected to be registered by the coming edge
   task automatic pushExpected(input logic [2:0] data, input logic src);
      expWord_t w;
      w.data = data;
      w.src  = src;
      scoreboard.push_back(w);
   endtask

   // Compare the registered output against the oldest expected word
   task automatic popAndCheck(input string tag);
      expWord_t w;
      testCount++;
      if (scoreboard.size() == 0) begin
         failCount++;
         $error("[TB] FAIL %s observed=scoreboard-empty expected=pending-word", tag);
      end else begin
         w = scoreboard.pop_front();
         checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
         checkOutput({tag, "_data"},  {29'd0, outData},  {29'd0, w.data});
         checkOutput({tag, "_src"},   {31'd0, outSrc},   {31'd0, w.src});
      end
   endtask

   initial begin
      rst_n = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
      cntClr = 1'b0;
`endif

      // Reset state: outputs cleared, select parked on requester 1
      rst_n = 1'b0;
      applyStimulus(1'b1, 3'b011, 1'b0, 3'd0, 1'b1);
      checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_out_data",  {29'd0, outData},  32'd0);
      checkOutput("rst_out_src",   {31'd0, outSrc},   32'd0);
      checkOutput("rst_req0_ready_gated", {31'd0, req0Ready}, 32'd0);
      checkOutput("rst_req1_ready", {31'd0, req1Ready}, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      checkOutput("rst_mux_sel_last_grant", {31'd0, muxSel}, 32'd1);
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
      checkOutput("rst_cnt0", {24'd0, grantCnt0}, 32'd0);
      checkOutput("rst_cnt1", {24'd0, grantCnt1}, 32'd0);
`endif

      // Release with nothing valid: stays idle
      tick();
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      tick();
      checkOutput("idle_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("idle_req0_ready", {31'd0, req0Ready}, 32'd0);
      checkOutput("idle_req1_ready", {31'd0, req1Ready}, 32'd0);

      // Single requester 1
      applyStimulus(1'b0, 3'd0, 1'b1, 3'b101, 1'b1);
      checkOutput("single_req1_ready", {31'd0, req1Ready}, 32'd1);
      checkOutput("single_req0_ready", {31'd0, req0Ready}, 32'd0);
      checkOutput("single_mux_sel",    {31'd0, muxSel},    32'd1);
      pushExpected(3'b101, 1'b1);
      tick();
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      popAndCheck("single");

      // Contention: grants alternate starting with requester 0
      applyStimulus(1'b1, 3'b001, 1'b1, 3'b110, 1'b1);
      for (int i = 0; i < 4; i++) begin
         logic expSrc;
         expSrc = i[0];
         checkOutput("cont_mux_sel",    {31'd0, muxSel},    {31'd0, expSrc});
         checkOutput("cont_req0_ready", {31'd0, req0Ready}, {31'd0, !expSrc});
         checkOutput("cont_req1_ready", {31'd0, req1Ready}, {31'd0, expSrc});
         pushExpected(expSrc ? 3'b110 : 3'b001, expSrc);
         tick();
         popAndCheck("cont");
      end

      // Backpressure: output full, consumer stalls for three cycles
      applyStimulus(1'b1, 3'b001, 1'b1, 3'b110, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_req0_ready", {31'd0, req0Ready}, 32'd0);
         checkOutput("bp_req1_ready", {31'd0, req1Ready}, 32'd0);
         checkOutput("bp_out_data",   {29'd0, outData},   {29'd0, 3'b110});
         checkOutput("bp_out_valid",  {31'd0, outValid},  32'd1);
         tick();
      end
      applyStimulus(1'b1, 3'b001, 1'b1, 3'b110, 1'b1);
      checkOutput("bp_release_req0_ready", {31'd0, req0Ready}, 32'd1);
      pushExpected(3'b001, 1'b0);
      tick();
      applyStimulus(1'b1, 3'b001, 1'b1, 3'b110, 1'b0);
      popAndCheck("bp_release");

      // Reset while full and stalled
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("midrst_out_data",  {29'd0, outData},  32'd0);
      checkOutput("midrst_req0_ready", {31'd0, req0Ready}, 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 3'b001, 1'b1, 3'b110, 1'b1);
      checkOutput("midrst_first_grant", {31'd0, muxSel}, 32'd0);
      checkOutput("midrst_req0_ready2", {31'd0, req0Ready}, 32'd1);
      pushExpected(3'b001, 1'b0);
      tick();
      popAndCheck("midrst_first");
      pushExpected(3'b110, 1'b1);
      tick();
      popAndCheck("midrst_second");

      // Drain without accept: valid drops, word and source hold
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      tick();
      checkOutput("drain_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("drain_out_data",  {29'd0, outData},  {29'd0, 3'b110});
      checkOutput("drain_out_src",   {31'd0, outSrc},   32'd1);

`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
      // Saturation after 300 accepts of requester 0
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      applyStimulus(1'b1, 3'b001, 1'b0, 3'd0, 1'b1);
      repeat (300) tick();
      checkOutput("cnt0_saturated", {24'd0, grantCnt0}, 32'd255);
      checkOutput("cnt1_untouched", {24'd0, grantCnt1}, 32'd0);
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      checkOutput("cnt0_cleared", {24'd0, grantCnt0}, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
`endif

      checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
